// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit valid/ready bus.
//   BUS_W      : bus data width
//   bus_data_t : one bus beat, used for bus data, FIFO storage and the output stream
package bus_pkg;
  localparam int unsigned BUS_W = 8;
  typedef logic [BUS_W-1:0] bus_data_t;
endpackage

// File: rtl/bus_if.sv
// Valid/ready bus bundle.
//   data  : byte driven by the master
//   valid : master has a byte on data
//   ready : slave can take the byte this cycle
// Modports: master drives data/valid and observes ready; slave the reverse.
interface bus_if;
  import bus_pkg::*;

  bus_data_t data;
  logic      valid;
  logic      ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bus_sync_fifo.sv
// First-word-fall-through synchronous FIFO: storage, read/write pointers and occupancy.
//   clk, rst_n : clock, synchronous active-low reset (clears pointers and level)
//   push/wdata : write wdata at the tail; caller guarantees not full
//   pop        : drop the head entry; caller guarantees not empty
//   rdata      : current head entry (valid whenever level != 0)
//   level      : number of stored entries, 0..DEPTH
module bus_sync_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         data_t = bus_data_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  data_t                      wdata,
  input  logic                       pop,
  output data_t                      rdata,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  data_t             mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;

  // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/bus_slave_rx_fifo.sv
// Slave-side receiver for the 8-bit valid/ready bus.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_data/in_valid     : byte offered by the bus master
//   in_ready             : slave accepts; depends on registered state and rst_n only
//   out_data/out_valid   : head of the FIFO (out_data is 0 when empty)
//   out_ready            : downstream takes the head byte
//   level                : FIFO occupancy
//   byte_cnt             : bytes accepted since reset, wraps silently
//   proto_err            : sticky flag, master withdrew or changed a stalled byte
module bus_slave_rx_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  bus_data_t              in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output bus_data_t              out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       byte_cnt,
  output logic                   proto_err
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  logic        push, pop;
  bus_data_t   head;

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             in_valid_q;
  bus_data_t        in_data_q;
  logic             stall_q;

  // Gating with rst_n keeps both handshakes closed on a reset edge.
  assign in_ready  = rst_n & (level != LvlFull);
  assign out_valid = rst_n & (level != '0);
  assign out_data  = out_valid ? head : '0;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  bus_sync_fifo #(
    .DEPTH  (DEPTH),
    .data_t (bus_data_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .level (level)
  );

  // A byte stalled last cycle must be held unchanged until accepted.
  always_comb begin
    byte_cnt_d  = byte_cnt_q + CNT_W'(push);
    proto_err_d = proto_err_q;
    if (stall_q && in_valid_q && (!in_valid || (in_data != in_data_q))) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      stall_q     <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      proto_err_q <= proto_err_d;
      in_valid_q  <= in_valid;
      in_data_q   <= in_data;
      stall_q     <= in_valid & ~in_ready;
    end
  end

  assign byte_cnt  = byte_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bus_slave_rx_fifo.sv
module tb_bus_slave_rx_fifo;
  import bus_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   out_ready = 1'b0;
  bus_data_t              out_data;
  logic                   out_valid;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       byte_cnt;
  logic                   proto_err;

  bus_if u_bus ();

  always #5 clk = ~clk;

  bus_slave_rx_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (u_bus.data),
    .in_valid  (u_bus.valid),
    .in_ready  (u_bus.ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .byte_cnt  (byte_cnt),
    .proto_err (proto_err)
  );

  // Reference model: a byte queue plus counters.
  logic [7:0]       mq[$];
  logic [CNT_W-1:0] m_cnt = '0;
  bit               m_err = 1'b0;
  bit               m_prev_stall = 1'b0;
  logic [7:0]       m_prev_data = '0;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit         rdy, vld, pop_m, push_m;
    logic [7:0] d;
    rdy = rst_n && (mq.size() < DEPTH);
    vld = u_bus.valid;
    d   = u_bus.data;
    if (!rst_n) begin
      mq.delete();
      m_cnt        = '0;
      m_err        = 1'b0;
      m_prev_stall = 1'b0;
    end else begin
      if (m_prev_stall && (!vld || d != m_prev_data)) m_err = 1'b1;
      pop_m  = (mq.size() != 0) && out_ready;
      push_m = vld && rdy;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back(d);
        m_cnt = m_cnt + 1'b1;
      end
      m_prev_stall = vld && !rdy;
    end
    m_prev_data = d;
  endtask

  task automatic check_all(input string tag);
    bit         ne;
    logic [7:0] hd;
    ne = rst_n && (mq.size() != 0);
    hd = ne ? mq[0] : 8'h00;
    check_eq({tag, ".in_ready"},  32'(u_bus.ready), 32'(rst_n && (mq.size() < DEPTH)));
    check_eq({tag, ".out_valid"}, 32'(out_valid),   32'(ne));
    check_eq({tag, ".out_data"},  32'(out_data),    32'(hd));
    check_eq({tag, ".level"},     32'(level),       mq.size());
    check_eq({tag, ".byte_cnt"},  32'(byte_cnt),    32'(m_cnt));
    check_eq({tag, ".proto_err"}, 32'(proto_err),   32'(m_err));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit ordy, input bit rn,
                      input string tag);
    u_bus.valid = v;
    u_bus.data  = d;
    out_ready   = ordy;
    rst_n       = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    u_bus.valid = 1'b0;
    u_bus.data  = '0;
    @(negedge clk);

    // Reset with valid held high: nothing may be stored.
    step(1'b1, 8'h33, 1'b0, 1'b0, "t1a");
    step(1'b1, 8'h33, 1'b0, 1'b0, "t1b");
    check_eq("t1.in_ready_low", 32'(u_bus.ready), 32'd0);

    // Single byte fall-through.
    step(1'b1, 8'hAA, 1'b0, 1'b1, "t2");
    check_eq("t2.head", 32'(out_data), 32'h0000_00AA);
    step(1'b0, 8'h00, 1'b1, 1'b1, "t2d");

    // Fill, hold a stalled byte steady, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1, "t3f");
    for (int i = 0; i < 3; i++)  step(1'b1, 8'h05, 1'b0, 1'b1, "t3h");
    check_eq("t3.full_ready", 32'(u_bus.ready), 32'd0);
    check_eq("t3.no_err", 32'(proto_err), 32'd0);
    step(1'b1, 8'h05, 1'b1, 1'b1, "t3p");
    step(1'b1, 8'h05, 1'b1, 1'b1, "t3p");
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b1, "t3d");

    // Streaming through the pointer wrap.
    step(1'b0, 8'h00, 1'b0, 1'b0, "t4r");
    for (int i = 0; i < 10; i++) step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b1, "t4s");
    step(1'b0, 8'h00, 1'b1, 1'b1, "t4e");
    check_eq("t4.cnt", 32'(byte_cnt), 32'd10);

    // Changing a stalled byte sets the sticky error.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1, "t5f");
    step(1'b1, 8'h55, 1'b0, 1'b1, "t5a");
    step(1'b1, 8'h66, 1'b0, 1'b1, "t5b");
    check_eq("t5.err_set", 32'(proto_err), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b1, "t5d");
    check_eq("t5.err_sticky", 32'(proto_err), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, "t5r");
    check_eq("t5.err_clr", 32'(proto_err), 32'd0);

    // Reset mid-operation drops buffered bytes.
    step(1'b0, 8'h00, 1'b0, 1'b1, "t6i");
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b1, "t6f");
    check_eq("t6.level3", 32'(level), 32'd3);
    step(1'b0, 8'h00, 1'b0, 1'b0, "t6r");
    check_eq("t6.level0", 32'(level), 32'd0);
    step(1'b1, 8'h77, 1'b0, 1'b1, "t6p");
    check_eq("t6.head", 32'(out_data), 32'h0000_0077);

    // Randomised traffic, mostly protocol-compliant, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      bit         v, o, r;
      logic [7:0] d;
      r = ($urandom_range(0, 79) != 0);
      o = ($urandom_range(0, 99) < 55);
      if (m_prev_stall && ($urandom_range(0, 99) < 90)) begin
        v = 1'b1;
        d = m_prev_data;
      end else begin
        v = ($urandom_range(0, 99) < 65);
        d = 8'($urandom_range(0, 255));
      end
      step(v, d, o, r, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
